// File: rtl/l2_pri_arb_pkg.sv
// l2_pri_arb_pkg: shared types and constants for the private L2 bank arbiter.
package l2_pri_arb_pkg;
   localparam int DATA_WIDTH = 32;
   localparam int BE_WIDTH   = 4;
   typedef enum logic [1:0] {INIT, RUN, DRAIN} state_e;
   typedef struct packed {
      logic valid;
      logic id;
      logic wen;
   } resp_t;
endpackage

// File: rtl/l2_rr_arb2.sv
// l2_rr_arb2: two-way round-robin arbiter; the pointer advances only on contended cycles.
module l2_rr_arb2 (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       en_i,
   input  logic [1:0] req_i,
   output logic [1:0] gnt_o
);
   logic ptr_q, ptr_d;
   always_comb begin
      gnt_o = !en_i ? 2'b00 : &req_i ? (ptr_q ? 2'b10 : 2'b01) : req_i;
      ptr_d = (en_i && &req_i) ? !ptr_q : ptr_q;
   end
   always_ff @(posedge clk_i) begin
      if (rst_i) ptr_q <= 1'b0;
      else       ptr_q <= ptr_d;
   end
endmodule

// File: rtl/l2_pri_bank_arbiter.sv
// l2_pri_bank_arbiter: shares one private L2 bank between two masters and zero-fills it on demand.
// Optional stall counters are built when L2_PRI_ARB_PERF_CNT_EN is defined.
module l2_pri_bank_arbiter
   import l2_pri_arb_pkg::*;
#(
   parameter int ADDR_WIDTH    = 13,
   parameter int BANK_SIZE     = 8192,
   parameter int INIT_ON_RESET = 1
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  init_start_i,
   output logic                  init_done_o,
   input  logic                  m0_req_i,
   output logic                  m0_gnt_o,
   input  logic [ADDR_WIDTH-1:0] m0_add_i,
   input  logic                  m0_wen_i,
   input  logic [BE_WIDTH-1:0]   m0_be_i,
   input  logic [DATA_WIDTH-1:0] m0_wdata_i,
   output logic                  m0_r_valid_o,
   output logic [DATA_WIDTH-1:0] m0_r_rdata_o,
   input  logic                  m1_req_i,
   output logic                  m1_gnt_o,
   input  logic [ADDR_WIDTH-1:0] m1_add_i,
   input  logic                  m1_wen_i,
   input  logic [BE_WIDTH-1:0]   m1_be_i,
   input  logic [DATA_WIDTH-1:0] m1_wdata_i,
   output logic                  m1_r_valid_o,
   output logic [DATA_WIDTH-1:0] m1_r_rdata_o,
   output logic                  mem_csn_o,
   output logic                  mem_wen_o,
   output logic [BE_WIDTH-1:0]   mem_be_o,
   output logic [ADDR_WIDTH-1:0] mem_add_o,
   output logic [DATA_WIDTH-1:0] mem_wdata_o,
   input  logic [DATA_WIDTH-1:0] mem_rdata_i
`ifdef L2_PRI_ARB_PERF_CNT_EN
   ,
   input  logic                  perf_clr_i,
   output logic [31:0]           m0_stall_cnt_o,
   output logic [31:0]           m1_stall_cnt_o
`endif
);
   localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(BANK_SIZE - 1);
   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] init_cnt_q, init_cnt_d;
   resp_t                 resp_q, resp_d;
   logic [1:0]            gnt;
   l2_rr_arb2 u_arb (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .en_i  (state_q == RUN && !init_start_i && !rst_i),
      .req_i ({m1_req_i, m0_req_i}),
      .gnt_o (gnt)
   );
   assign m0_gnt_o    = gnt[0];
   assign m1_gnt_o    = gnt[1];
   assign init_done_o = state_q == RUN;
   always_comb begin
      state_d     = state_q;
      init_cnt_d  = init_cnt_q;
      mem_csn_o   = 1'b1;
      mem_wen_o   = 1'b1;
      mem_be_o    = '0;
      mem_add_o   = '0;
      mem_wdata_o = '0;
      resp_d      = '{valid: |gnt, id: gnt[1], wen: gnt[1] ? m1_wen_i : m0_wen_i};
      if (!rst_i) begin
         if (state_q == INIT) begin
            mem_csn_o  = 1'b0;
            mem_wen_o  = 1'b0;
            mem_be_o   = '1;
            mem_add_o  = init_cnt_q;
            init_cnt_d = init_cnt_q + 1'b1;
            if (init_cnt_q == LAST) begin
               state_d    = RUN;
               init_cnt_d = '0;
            end
         end else if (state_q == DRAIN) begin
            state_d    = INIT;
            init_cnt_d = '0;
         end else if (init_start_i) begin
            state_d = DRAIN;
         end else if (|gnt) begin
            mem_csn_o   = 1'b0;
            mem_wen_o   = gnt[1] ? m1_wen_i   : m0_wen_i;
            mem_be_o    = gnt[1] ? m1_be_i    : m0_be_i;
            mem_add_o   = gnt[1] ? m1_add_i   : m0_add_i;
            mem_wdata_o = gnt[1] ? m1_wdata_i : m0_wdata_i;
         end
      end
   end
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= (INIT_ON_RESET != 0) ? INIT : RUN;
         init_cnt_q <= '0;
         resp_q     <= '0;
      end else begin
         state_q    <= state_d;
         init_cnt_q <= init_cnt_d;
         resp_q     <= resp_d;
      end
   end
   // Write responses return zero data; only the addressed master sees anything.
   assign m0_r_valid_o = resp_q.valid && !resp_q.id;
   assign m1_r_valid_o = resp_q.valid &&  resp_q.id;
   assign m0_r_rdata_o = (m0_r_valid_o && resp_q.wen) ? mem_rdata_i : '0;
   assign m1_r_rdata_o = (m1_r_valid_o && resp_q.wen) ? mem_rdata_i : '0;
`ifdef L2_PRI_ARB_PERF_CNT_EN
   logic [1:0][31:0] stall_q, stall_d;
   logic [1:0]       req;
   assign req = {m1_req_i, m0_req_i};
   always_comb begin
      stall_d = stall_q;
      for (int n = 0; n < 2; n++)
         stall_d[n] = perf_clr_i ? '0 :
                      (state_q == RUN && req[n] && !gnt[n] && !(&stall_q[n])) ? stall_q[n] + 1'b1 :
                      stall_q[n];
   end
   always_ff @(posedge clk_i) begin
      if (rst_i) stall_q <= '0;
      else       stall_q <= stall_d;
   end
   assign m0_stall_cnt_o = stall_q[0];
   assign m1_stall_cnt_o = stall_q[1];
`endif
endmodule

// File: tb/tb_l2_pri_bank_arbiter.sv
// tb_l2_pri_bank_arbiter: directed self-checking bench with a behavioural bank model.
module tb_l2_pri_bank_arbiter;
   logic        clk = 1'b0;
   logic        rst_i, init_start_i, init_done_o;
   logic        m0_req_i, m0_gnt_o, m0_wen_i, m0_r_valid_o;
   logic [12:0] m0_add_i;
   logic [3:0]  m0_be_i;
   logic [31:0] m0_wdata_i, m0_r_rdata_o;
   logic        m1_req_i, m1_gnt_o, m1_wen_i, m1_r_valid_o;
   logic [12:0] m1_add_i;
   logic [3:0]  m1_be_i;
   logic [31:0] m1_wdata_i, m1_r_rdata_o;
   logic        mem_csn_o, mem_wen_o;
   logic [3:0]  mem_be_o;
   logic [12:0] mem_add_o;
   logic [31:0] mem_wdata_o, mem_rdata_i;
`ifdef L2_PRI_ARB_PERF_CNT_EN
   logic        perf_clr_i;
   logic [31:0] m0_stall_cnt_o, m1_stall_cnt_o;
`endif
   int checks = 0;
   int errors = 0;
   logic [31:0] mem [0:8191];
   always #5 clk = ~clk;

   l2_pri_bank_arbiter dut (
      .clk_i(clk), .rst_i(rst_i), .init_start_i(init_start_i), .init_done_o(init_done_o),
      .m0_req_i(m0_req_i), .m0_gnt_o(m0_gnt_o), .m0_add_i(m0_add_i), .m0_wen_i(m0_wen_i),
      .m0_be_i(m0_be_i), .m0_wdata_i(m0_wdata_i), .m0_r_valid_o(m0_r_valid_o), .m0_r_rdata_o(m0_r_rdata_o),
      .m1_req_i(m1_req_i), .m1_gnt_o(m1_gnt_o), .m1_add_i(m1_add_i), .m1_wen_i(m1_wen_i),
      .m1_be_i(m1_be_i), .m1_wdata_i(m1_wdata_i), .m1_r_valid_o(m1_r_valid_o), .m1_r_rdata_o(m1_r_rdata_o),
      .mem_csn_o(mem_csn_o), .mem_wen_o(mem_wen_o), .mem_be_o(mem_be_o), .mem_add_o(mem_add_o),
      .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
`ifdef L2_PRI_ARB_PERF_CNT_EN
      , .perf_clr_i(perf_clr_i), .m0_stall_cnt_o(m0_stall_cnt_o), .m1_stall_cnt_o(m1_stall_cnt_o)
`endif
   );

   always @(posedge clk) begin
      if (!mem_csn_o) begin
         if (mem_wen_o) mem_rdata_i <= mem[mem_add_o];
         else for (int b = 0; b < 4; b++)
            if (mem_be_o[b]) mem[mem_add_o][8*b +: 8] <= mem_wdata_o[8*b +: 8];
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic m0_set(input logic r, input logic w, input logic [12:0] a, input logic [31:0] d);
      m0_req_i = r; m0_wen_i = w; m0_add_i = a; m0_wdata_i = d; m0_be_i = 4'hF;
   endtask

   task automatic m1_set(input logic r, input logic w, input logic [12:0] a, input logic [31:0] d, input logic [3:0] be);
      m1_req_i = r; m1_wen_i = w; m1_add_i = a; m1_wdata_i = d; m1_be_i = be;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog time limit reached");
      $fatal(1);
   end

   initial begin
      int bad, nw;
      logic done;
      logic [1:0] exp_g, prev_g;
      rst_i = 1'b1; init_start_i = 1'b0;
      m0_set(1'b1, 1'b1, '0, '0);
      m1_set(1'b0, 1'b1, '0, '0, 4'h0);
`ifdef L2_PRI_ARB_PERF_CNT_EN
      perf_clr_i = 1'b0;
`endif
      step(); step();
      @(negedge clk);
      chk("rst_m0_gnt", m0_gnt_o, 0);
      chk("rst_csn", mem_csn_o, 1);
      chk("rst_wen", mem_wen_o, 1);
      chk("rst_be", mem_be_o, 0);
      chk("rst_add", mem_add_o, 0);
      chk("rst_init_done", init_done_o, 0);
      chk("rst_rvalid", {m1_r_valid_o, m0_r_valid_o}, 0);
      chk("rst_rdata0", m0_r_rdata_o, 0);
`ifdef L2_PRI_ARB_PERF_CNT_EN
      chk("rst_stall1", m1_stall_cnt_o, 0);
`endif
      step(); rst_i = 1'b0;
      bad = 0;
      for (int i = 0; i < 8192; i++) begin
         @(negedge clk);
         if (mem_add_o !== 13'(i) || mem_csn_o !== 1'b0 || mem_wen_o !== 1'b0 || mem_be_o !== 4'hF ||
             mem_wdata_o !== 32'h0 || m0_gnt_o !== 1'b0 || init_done_o !== 1'b0) bad++;
         step();
         init_start_i = (i == 99);
      end
      @(negedge clk);
      chk("fill_bad_cycles", bad, 0);
      chk("fill_done", init_done_o, 1);
      chk("fill_first_gnt", m0_gnt_o, 1);
      chk("fill_mem_last", mem[8191], 0);
      chk("fill_mem_mid", mem[4000], 0);

      step(); m0_set(1'b1, 1'b0, 13'h10, 32'hDEADBEEF);
      step(); m0_set(1'b1, 1'b0, 13'h1, 32'h11111111);
      step(); m0_set(1'b1, 1'b0, 13'h2, 32'h22222222);
      step(); m0_set(1'b1, 1'b1, 13'h10, '0);
      @(negedge clk);
      chk("rd_gnt_same_cycle", m0_gnt_o, 1);
      chk("rd_m1_gnt", m1_gnt_o, 0);
      chk("rd_csn", mem_csn_o, 0);
      chk("rd_add", mem_add_o, 32'h10);
      chk("wr_resp_prev_rdata", m0_r_rdata_o, 0);
      step(); m0_set(1'b0, 1'b1, '0, '0);
      @(negedge clk);
      chk("rd_valid", m0_r_valid_o, 1);
      chk("rd_data", m0_r_rdata_o, 32'hDEADBEEF);
      chk("rd_m1_valid", m1_r_valid_o, 0);
      chk("rd_m1_rdata", m1_r_rdata_o, 0);
      chk("idle_csn", mem_csn_o, 1);

      prev_g = 2'b00;
      for (int k = 0; k < 4; k++) begin
         step();
         m0_set(1'b1, 1'b1, 13'h1, '0);
         m1_set(1'b1, 1'b1, 13'h2, '0, 4'hF);
         @(negedge clk);
         exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
         chk($sformatf("cont_gnt_%0d", k), {m1_gnt_o, m0_gnt_o}, exp_g);
         chk($sformatf("cont_resp_%0d", k), {m1_r_valid_o, m0_r_valid_o}, prev_g);
         if (k > 0) chk($sformatf("cont_rdata_%0d", k), prev_g[0] ? m0_r_rdata_o : m1_r_rdata_o,
                        prev_g[0] ? 32'h11111111 : 32'h22222222);
         prev_g = exp_g;
      end
      step(); m0_set(1'b0, 1'b1, '0, '0); m1_set(1'b0, 1'b1, '0, '0, 4'h0);
      @(negedge clk);
      chk("cont_last_resp", {m1_r_valid_o, m0_r_valid_o}, 2'b10);
      chk("cont_last_rdata", m1_r_rdata_o, 32'h22222222);

      step(); m1_set(1'b1, 1'b0, 13'h20, 32'h12345678, 4'b0011);
      @(negedge clk);
      chk("wr_gnt", m1_gnt_o, 1);
      chk("wr_mem_wen", mem_wen_o, 0);
      chk("wr_mem_be", mem_be_o, 4'b0011);
      chk("wr_mem_wdata", mem_wdata_o, 32'h12345678);
      step(); m1_set(1'b1, 1'b1, 13'h20, '0, 4'hF);
      @(negedge clk);
      chk("wr_resp_valid", m1_r_valid_o, 1);
      chk("wr_resp_rdata", m1_r_rdata_o, 0);
      step(); m1_set(1'b0, 1'b1, '0, '0, 4'h0);
      @(negedge clk);
      chk("wr_readback", m1_r_rdata_o, 32'h00005678);
      chk("wr_readback_m0", m0_r_valid_o, 0);

`ifdef L2_PRI_ARB_PERF_CNT_EN
      step(); perf_clr_i = 1'b1;
      step(); perf_clr_i = 1'b0;
      @(negedge clk);
      chk("perf_clr_m0", m0_stall_cnt_o, 0);
      for (int k = 0; k < 6; k++) begin
         m0_set(1'b1, 1'b1, 13'h1, '0);
         m1_set(1'b1, 1'b1, 13'h2, '0, 4'hF);
         step();
      end
      m0_set(1'b0, 1'b1, '0, '0); m1_set(1'b0, 1'b1, '0, '0, 4'h0);
      @(negedge clk);
      chk("perf_m1_stall", m1_stall_cnt_o, 3);
      chk("perf_m0_stall", m0_stall_cnt_o, 3);
      step();
      m0_set(1'b1, 1'b1, 13'h1, '0); m1_set(1'b1, 1'b1, 13'h2, '0, 4'hF); perf_clr_i = 1'b1;
      step();
      m0_set(1'b0, 1'b1, '0, '0); m1_set(1'b0, 1'b1, '0, '0, 4'h0); perf_clr_i = 1'b0;
      @(negedge clk);
      chk("perf_clr_wins_m0", m0_stall_cnt_o, 0);
      chk("perf_clr_wins_m1", m1_stall_cnt_o, 0);
`endif

      step(); m0_set(1'b1, 1'b1, 13'h10, '0);
      @(negedge clk);
      chk("reinit_pre_gnt", m0_gnt_o, 1);
      step(); init_start_i = 1'b1;
      @(negedge clk);
      chk("reinit_start_gnt", m0_gnt_o, 0);
      chk("reinit_start_csn", mem_csn_o, 1);
      chk("reinit_resp_valid", m0_r_valid_o, 1);
      chk("reinit_resp_data", m0_r_rdata_o, 32'hDEADBEEF);
      step(); init_start_i = 1'b0;
      @(negedge clk);
      chk("drain_gnt", m0_gnt_o, 0);
      chk("drain_done", init_done_o, 0);
      chk("drain_csn", mem_csn_o, 1);
      chk("drain_resp", m0_r_valid_o, 0);
      done = 1'b0; nw = 0;
      for (int i = 0; i < 9000 && !done; i++) begin
         step();
         @(negedge clk);
         if (m0_gnt_o) done = 1'b1;
         else if (!mem_csn_o && !mem_wen_o && mem_be_o == 4'hF && mem_wdata_o == 0 && mem_add_o == 13'(nw)) nw++;
      end
      chk("reinit_resumed", done, 1);
      chk("reinit_writes", nw, 8192);
      chk("reinit_done", init_done_o, 1);
      step(); m0_set(1'b0, 1'b1, '0, '0);
      @(negedge clk);
      chk("reinit_zero_valid", m0_r_valid_o, 1);
      chk("reinit_zero_data", m0_r_rdata_o, 0);

      step(); m0_set(1'b1, 1'b1, 13'h10, '0); rst_i = 1'b1;
      @(negedge clk);
      chk("rstrun_gnt", m0_gnt_o, 0);
      step(); rst_i = 1'b0; m0_set(1'b0, 1'b1, '0, '0);
      @(negedge clk);
      chk("rstrun_no_resp", m0_r_valid_o, 0);
      chk("rstrun_init_add0", mem_add_o, 0);
      step(); step();
      @(negedge clk);
      chk("midinit_add2", mem_add_o, 2);
      step(); rst_i = 1'b1;
      step(); rst_i = 1'b0;
      @(negedge clk);
      chk("midinit_restart_add", mem_add_o, 0);
      chk("midinit_restart_csn", mem_csn_o, 0);
`ifdef L2_PRI_ARB_PERF_CNT_EN
      chk("midinit_stall_m0", m0_stall_cnt_o, 0);
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
